pixel_line_fetch: RTL and testbench
===================================

PIXEL_LINE_FETCH -- requirements
Module: pixel_line_fetch

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line; SHALL be a multiple of 4.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter FRAME_BASE, default 27'h0, byte address of pixel (0,0).
REQ-004 Parameter WORDS, default H_ACTIVE/4, 128-bit words per line; line stride SHALL be H_ACTIVE*4 bytes.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 hc_visible  in  11  0 = horizontal blanking; k>0 = pixel x=k-1.
REQ-008 vc_visible  in  11  0 = vertical blanking; k>0 = line y=k-1.
REQ-009 rd_req  out  1  line read request to DDR controller.
REQ-010 rd_addr  out  27  byte address of requested line.
REQ-011 rd_len  out  8  beat count of request; constant WORDS.
REQ-012 rd_ack  in  1  request accepted in this cycle.
REQ-013 rd_data_valid  in  1  rd_data beat valid.
REQ-014 rd_data  in  128  4 pixels; lane n = bits[32n+23:32n] = {R,G,B}; bits[32n+31:32n+24] ignored.
REQ-015 R_memory, G_memory, B_memory  out  8 each  pixel to downstream RGB_display.
REQ-016 underflow  out  1  sticky: a line was displayed before its fetch completed.

Function
REQ-017 Storage SHALL be two line buffers (ping-pong), each WORDS x 96 bits; line y SHALL reside in buffer y[0].
REQ-018 Per-buffer valid flag SHALL clear when a fetch into that buffer starts and set on its final beat.
REQ-019 FSM states SHALL be IDLE, REQ, RECV.
REQ-020 IDLE -> REQ when a fetch is pending; rd_addr = FRAME_BASE + y*H_ACTIVE*4 loaded same edge.
REQ-021 In REQ, rd_req SHALL be 1 with rd_addr stable; the cycle rd_ack=1 SHALL deassert rd_req next edge and enter RECV.
REQ-022 In RECV, each rd_data_valid beat SHALL write buffer word at beat counter (0..WORDS-1); after beat WORDS-1 -> IDLE and valid flag set.
REQ-023 rd_data_valid outside RECV SHALL be ignored.
REQ-024 Fetch of line 0 SHALL be triggered on the first cycle vc_visible==0 after reset or after vc_visible leaves V_ACTIVE.
REQ-025 Fetch of line y+1 SHALL be triggered on the cycle vc_visible changes to y+1 (line y begins), for y+1 < V_ACTIVE; no fetch after line V_ACTIVE-1.
REQ-026 A trigger while FSM is not IDLE SHALL set a single pending flag (with line number), served on return to IDLE; a second trigger before service SHALL overwrite it.
REQ-027 Output latency SHALL be exactly 1 clock: outputs at edge t+1 reflect hc_visible/vc_visible sampled at t.
REQ-028 Pixel select: word = x>>2, lane = x[1:0]; R=[23:16], G=[15:8], B=[7:0] of lane.
REQ-029 Outputs SHALL be 8'h00 when hc_visible==0 or vc_visible==0.
REQ-030 If visible pixel requested and buffer y[0] valid flag is 0, outputs SHALL be 8'h00 and underflow SHALL set to 1 next edge.
REQ-031 underflow SHALL clear only by reset.
REQ-032 Line index arithmetic SHALL be 11-bit unsigned; address product 27-bit, no wrap within V_ACTIVE.

Reset
REQ-033 resetn=0 at an edge SHALL force: FSM IDLE, rd_req=0, rd_addr=0, beat counter 0, both valid flags 0, pending 0, R/G/B_memory=8'h00, underflow=0.
REQ-034 Reset mid-fetch SHALL abandon the fetch; remaining beats are dropped per REQ-023; DDR controller shares resetn.
REQ-035 Reset release SHALL not itself trigger a fetch; REQ-024 governs.

Verification
REQ-036 Reset, vc_visible=0 -> rd_req=1, rd_addr=0, rd_len=160; hold rd_ack=0 5 cycles -> rd_req and rd_addr stable.
REQ-037 Ack, 160 beats lane0 word0=24'hA1B2C3 -> vc=1,hc=1 -> next edge R/G/B=A1/B2/C3; same edge rd_req=1, rd_addr=0xA00.
REQ-038 hc=6 (x=5) with word1 lane1=24'h102030 -> outputs 10/20/30 one cycle later; hc=0 -> 00/00/00.
REQ-039 Withhold beats of line 1, advance vc to 2 -> outputs 00, underflow=1, stays 1 through later frames until resetn=0.
REQ-040 Assert resetn=0 at beat 80 of a fetch, 80 stray beats follow -> no buffer write, valid flags 0, rd_req=0 until vc_visible=0 retriggers line 0.
REQ-041 Full frame vc 0->480->0 with timely beats -> 480 requests, addresses 0..0x12B600 step 0xA00, no underflow, line 0 refetched next frame.

Source files
------------

// File: rtl/pixel_line_fetch.sv
// pixel_line_fetch: ping-pong line buffers filled from DDR one raster line ahead,
// with a one-clock RGB lookup for the current raster position.
module pixel_line_fetch #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [26:0] FRAME_BASE = 27'h0,
    parameter int          WORDS      = H_ACTIVE / 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [10:0]  hc_visible,
    input  logic [10:0]  vc_visible,
    output logic         rd_req,
    output logic [26:0]  rd_addr,
    output logic [7:0]   rd_len,
    input  logic         rd_ack,
    input  logic         rd_data_valid,
    input  logic [127:0] rd_data,
    output logic [7:0]   R_memory,
    output logic [7:0]   G_memory,
    output logic [7:0]   B_memory,
    output logic         underflow
);
    localparam int          WA     = $clog2(WORDS);
    localparam logic [26:0] STRIDE = 27'(H_ACTIVE * 4);
    localparam logic [10:0] V_END  = 11'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;

    state_t      state;
    logic [95:0] mem [2][WORDS];
    logic [7:0]  beat;
    logic        buf_sel;
    logic [1:0]  valid;
    logic        pend;
    logic [10:0] pend_line;
    logic [10:0] vc_prev;
    logic        armed;
    logic        seen;
    logic        leave;
    logic        trig0;
    logic        trign;
    logic        trig;
    logic        miss;
    logic [10:0] trig_line;
    logic [10:0] fetch_line;
    logic [10:0] x;
    logic [10:0] y;
    logic [95:0] word;
    logic [23:0] pix;
    logic [95:0] packed_beat;
    logic        unused_bits;

    assign rd_len      = 8'(WORDS);
    assign packed_beat = {rd_data[119:96], rd_data[87:64], rd_data[55:32], rd_data[23:0]};
    assign unused_bits = ^{rd_data[127:120], rd_data[95:88], rd_data[63:56], rd_data[31:24],
                           x[10:WA+2], y[10:1]};

    // line 0 is fetched once per frame: after reset or once vc has left the last line
    always_comb begin
        leave      = seen && vc_prev == V_END && vc_visible != V_END;
        trig0      = vc_visible == 11'd0 && (armed || leave);
        trign      = seen && vc_visible != vc_prev && vc_visible != 11'd0 && vc_visible < V_END;
        trig       = trig0 || trign;
        trig_line  = trig0 ? 11'd0 : vc_visible;
        fetch_line = trig ? trig_line : pend_line;
        x          = hc_visible - 11'd1;
        y          = vc_visible - 11'd1;
        word       = mem[y[0]][x[WA+1:2]];
        pix        = word[24*x[1:0] +: 24];
        miss       = hc_visible != 11'd0 && vc_visible != 11'd0 && !valid[y[0]];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            rd_req    <= 1'b0;
            rd_addr   <= 27'd0;
            beat      <= 8'd0;
            buf_sel   <= 1'b0;
            valid     <= 2'b00;
            pend      <= 1'b0;
            pend_line <= 11'd0;
            vc_prev   <= 11'd0;
            armed     <= 1'b1;
            seen      <= 1'b0;
        end else begin
            seen    <= 1'b1;
            vc_prev <= vc_visible;
            armed   <= trig0 ? 1'b0 : (leave ? 1'b1 : armed);
            case (state)
                IDLE: if (trig || pend) begin
                    state               <= REQ;
                    rd_req              <= 1'b1;
                    rd_addr             <= FRAME_BASE + 27'(fetch_line) * STRIDE;
                    buf_sel             <= fetch_line[0];
                    valid[fetch_line[0]] <= 1'b0;
                    pend                <= 1'b0;
                end
                REQ: if (rd_ack) begin
                    state  <= RECV;
                    rd_req <= 1'b0;
                    beat   <= 8'd0;
                end
                RECV: if (rd_data_valid) begin
                    beat <= beat + 8'd1;
                    if (beat == 8'(WORDS - 1)) begin
                        state          <= IDLE;
                        valid[buf_sel] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // a trigger during a fetch is remembered once; a newer one replaces it
            if (trig && state != IDLE) begin
                pend      <= 1'b1;
                pend_line <= trig_line;
            end
        end
    end

    always_ff @(posedge clk)
        if (resetn && state == RECV && rd_data_valid)
            mem[buf_sel][beat[WA-1:0]] <= packed_beat;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            {R_memory, G_memory, B_memory} <= 24'h0;
            underflow                      <= 1'b0;
        end else begin
            {R_memory, G_memory, B_memory} <= (hc_visible == 11'd0 || vc_visible == 11'd0 || miss) ? 24'h0 : pix;
            underflow                      <= underflow || miss;
        end
    end
endmodule

// File: tb/tb_pixel_line_fetch.sv
// tb_pixel_line_fetch: random raster and DDR traffic against a line-level model;
// expected pixels and requests are queued by the driver and checked by a monitor.
module tb_pixel_line_fetch;
    localparam int          H    = 64;
    localparam int          V    = 20;
    localparam int          W    = H / 4;
    localparam logic [26:0] BASE = 27'h40000;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [10:0]  hc_visible = 11'd0;
    logic [10:0]  vc_visible = 11'd0;
    logic         rd_req;
    logic [26:0]  rd_addr;
    logic [7:0]   rd_len;
    logic         rd_ack = 1'b0;
    logic         rd_data_valid = 1'b0;
    logic [127:0] rd_data = 128'd0;
    logic [7:0]   R_memory;
    logic [7:0]   G_memory;
    logic [7:0]   B_memory;
    logic         underflow;

    typedef struct {int due; logic [23:0] rgb; logic uf;} pix_t;
    pix_t        pix_q[$];
    logic [26:0] req_q[$];
    pix_t        m_e;
    int total = 0, bad = 0, cyc = 0;

    // model: what each buffer holds (line, data generation) and the DDR transfer in flight
    bit m_valid[2];
    int m_gen_of[2], m_line_of[2];
    int m_state = 0, m_line = 0, m_gen = 0, m_beat = 0, gen_cnt = 0;
    bit m_pend = 0, m_armed = 1, m_seen = 0, m_uf = 0;
    int m_pl = 0, m_vprev = 0;
    bit hold_v = 0, ack_prev = 0;
    logic [26:0] hold_a = 27'd0;

    pixel_line_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_BASE(BASE)) dut (
        .clk(clk), .resetn(resetn), .hc_visible(hc_visible), .vc_visible(vc_visible),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .R_memory(R_memory), .G_memory(G_memory), .B_memory(B_memory), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] px(input int g, input int l, input int x);
        return 24'((g * 977 + l * 131 + x * 7) ^ (x << 13) ^ (g << 17) ^ (l << 9));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic start_fetch(input int l);
        m_valid[l % 2]   = 0;
        m_line_of[l % 2] = l;
        gen_cnt++;
        m_gen_of[l % 2]  = gen_cnt;
        m_line  = l;
        m_gen   = gen_cnt;
        m_state = 1;
        m_pend  = 0;
        req_q.push_back(BASE + 27'(l * H * 4));
    endtask

    // one clock: drive inputs, predict the edge, queue the expected outputs
    task automatic step(input int h, input int v, input bit rn, input bit stray);
        pix_t e;
        bit   trig;
        int   tl, ps;
        hc_visible    = 11'(h);
        vc_visible    = 11'(v);
        resetn        = rn;
        rd_ack        = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = {$urandom, $urandom, $urandom, $urandom};
        if (rn && m_state == 1 && rd_req === 1'b1 && $urandom_range(0, 2) == 0) rd_ack = 1'b1;
        else if (rn && m_state == 2 && $urandom_range(0, 3) != 0) begin
            rd_data_valid = 1'b1;
            for (int k = 0; k < 4; k++) rd_data[32*k +: 24] = px(m_gen, m_line, 4 * m_beat + k);
        end else if (stray) rd_data_valid = 1'b1;
        e.due = cyc + 1;
        e.rgb = 24'h0;
        if (!rn) begin
            m_valid = '{0, 0};
            m_state = 0;
            m_pend  = 0;
            m_armed = 1;
            m_seen  = 0;
            m_uf    = 0;
            req_q.delete();
        end else begin
            if (h != 0 && v != 0) begin
                if (m_valid[(v - 1) % 2]) e.rgb = px(m_gen_of[(v - 1) % 2], m_line_of[(v - 1) % 2], h - 1);
                else m_uf = 1;
            end
            if (m_seen && m_vprev == V && v != V) m_armed = 1;
            trig = 0;
            tl   = v;
            if (v == 0 && m_armed) begin
                trig    = 1;
                tl      = 0;
                m_armed = 0;
            end else if (m_seen && v != m_vprev && v != 0 && v < V) trig = 1;
            ps = m_state;
            if (m_state == 0) begin
                if (trig) start_fetch(tl);
                else if (m_pend) start_fetch(m_pl);
            end else if (m_state == 1) begin
                if (rd_ack) begin
                    m_state = 2;
                    m_beat  = 0;
                end
            end else if (rd_data_valid) begin
                m_beat++;
                if (m_beat == W) begin
                    m_valid[m_line % 2] = 1;
                    m_state = 0;
                end
            end
            if (trig && ps != 0) begin
                m_pend = 1;
                m_pl   = tl;
            end
            m_seen  = 1;
            m_vprev = v;
        end
        e.uf = m_uf;
        pix_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n, input int lo, input int hi);
        int period;
        for (int f = 0; f < n; f++)
            for (int v = 0; v <= V; v++) begin
                period = $urandom_range(lo, hi);
                for (int c = 0; c < period; c++) step(c < 3 ? 0 : $urandom_range(0, H), v, 1, 0);
            end
    endtask

    always @(negedge clk) begin
        if (pix_q.size() != 0 && pix_q[0].due == cyc) begin
            m_e = pix_q.pop_front();
            check("rgb", {8'h0, R_memory, G_memory, B_memory}, {8'h0, m_e.rgb});
            check("underflow", 32'(underflow), 32'(m_e.uf));
        end
        if (resetn && req_q.size() == 0) check("spurious_req", 32'(rd_req), 32'd0);
        if (rd_req === 1'b1 && hold_v) check("addr_hold", 32'(rd_addr), 32'(hold_a));
        if (ack_prev) check("req_drop", 32'(rd_req), 32'd0);
        if (rd_req === 1'b1 && rd_ack && req_q.size() != 0) begin
            check("rd_addr", 32'(rd_addr), 32'(req_q.pop_front()));
            check("rd_len", 32'(rd_len), W);
        end
        hold_v   = rd_req === 1'b1 && !rd_ack;
        hold_a   = rd_addr;
        ack_prev = rd_req === 1'b1 && rd_ack;
    end

    initial begin
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        run_frames(3, 36, 50);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        run_frames(2, 6, 30);
        for (int i = 0; i < 400 && !(m_state == 2 && m_beat == W / 2); i++) step(0, 0, 1, 0);
        step(0, 5, 0, 0);
        for (int i = 0; i < W / 2; i++) step(0, 5, 1, 1);
        for (int i = 0; i < 6; i++) step($urandom_range(1, H), 2, 1, 0);
        run_frames(1, 36, 50);
        for (int i = 0; i < 60; i++) step(0, V, 1, 0);
        @(negedge clk);
        #1;
        check("pix_left", 32'(pix_q.size()), 32'd0);
        check("req_left", 32'(req_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
